seg_scan_decoder: RTL
=====================

Name: seg_scan_decoder

Overview:
- Reverse-direction companion to the team's hex-to-7-segment encoder.
- Passively monitors a multiplexed 8-digit 7-segment scan bus and recovers the hex nibble, decimal point and status of each digit.
- Intended uses: on-board self-test loopback and bench-side checking of display drivers.
- Sits after the scan/mux logic, in the system clock domain.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples of (an_in, seg_in) required before a digit is captured; legal range 2..255.
- NUM_DIGITS, 8: number of scanned digits; fixed at 8 in this revision.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- an_in  input  8  digit select, active-high; one-hot when legal
- seg_in  input  8  segment pattern, active-high; bit7=a .. bit1=g, bit0=dp
- clear  input  1  synchronous clear of captured data and frame mask
- hex_out  output  32  recovered nibbles; digit i at [4i+3:4i]
- dp_out  output  8  recovered decimal point per digit
- valid_out  output  8  digit i holds a recognised hex glyph
- blank_out  output  8  digit i was captured with segments a..g all off
- err_out  output  8  digit i was captured with an unrecognised glyph
- sel_err  output  1  sticky flag: an_in seen multi-hot
- frame_done  output  1  one-cycle pulse when all 8 digits have been captured since the last pulse or clear

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0, FSM in S_WAIT, stability counter 0, frame mask 0.
- Input registers: an_in and seg_in are sampled every clock into sel_q and seg_q. A sample is "same" if it equals the previous sample.
- S_WAIT:
  - Entered whenever an_in is not one-hot. Counter is held at 0.
  - If an_in has 2 or more bits set, sel_err is set. It stays set until reset or clear.
  - An all-zero an_in (scan gap) is legal and does not set sel_err.
  - Exits to S_SETTLE on a one-hot sample; the counter is set to 1.
- S_SETTLE:
  - A same sample increments the counter.
  - A differing one-hot sample restarts the count at 1.
  - A non-one-hot sample returns to S_WAIT.
  - When the counter reaches STABLE_CYCLES, capture occurs at that clock edge and the FSM moves to S_HELD. Outputs are visible in the following cycle.
- S_HELD:
  - Holds with no further captures while samples stay the same.
  - Any change goes to S_SETTLE (one-hot sample, counter set to 1) or to S_WAIT (non-one-hot sample).
  - Result: exactly one capture per dwell.
- Capture into digit i (i = index of the set an_in bit):
  - dp_out[i] = seg bit0.
  - Decode of seg[7:1] (a..g): 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=73, A=77, b=1F, C=4E, d=3D, E=4F, F=47.
  - Match: hex nibble = value, valid=1, blank=0, err=0.
  - seg[7:1]=00: nibble=0, blank=1, valid=0, err=0.
  - Any other pattern: nibble=0, err=1, valid=0, blank=0.
  - The previous contents of digit i are fully overwritten. Other digits are untouched.
- Frame mask:
  - Bit i is set on capture of digit i.
  - When a capture makes the mask all-ones, frame_done pulses high for exactly the next cycle and the mask clears to 0 in the same cycle.
  - Repeated captures of an already-masked digit update its data but have no effect on the mask.
- clear:
  - Zeroes hex_out, dp_out, valid_out, blank_out, err_out, sel_err and the mask at the next edge. FSM and counter are unaffected.
  - If clear and a capture occur in the same cycle, clear wins: no data is written and the mask stays 0.
  - frame_done is suppressed in that cycle.
- Reset mid-settle: the count is discarded. The first capture after reset requires a full STABLE_CYCLES dwell.

Test Plan:
- Reset then idle with an_in=00 for 20 cycles -> all outputs 0, sel_err=0, no frame_done.
- an_in=01, seg_in=FC held 4 cycles (STABLE_CYCLES=4) -> after the 4th edge: hex_out[3:0]=0, valid_out[0]=1, dp_out[0]=0. Held 3 cycles only -> no change.
- Scan 8 digits showing 0..7, each held 6 cycles, each with seg_in bit0=1 -> hex_out=0x76543210, dp_out=FF, valid_out=FF, a single frame_done pulse after digit 7, mask cleared.
- an_in=04, seg_in=00 for 5 cycles, then an_in=08, seg_in=0x92 for 5 cycles -> blank_out[2]=1, err_out[3]=1, both valid bits 0.
- an_in=03 for 1 cycle -> sel_err=1 and no capture. Then assert clear together with the capturing edge of a legal digit -> all outputs 0 and no frame_done.
- seg_in toggles every 2 cycles on digit 5 for 20 cycles, then holds 0xE6 -> exactly one capture, hex nibble 9, occurring 4 samples after the final change. Pulse rst_n low during a settle -> all outputs 0 immediately.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: passive monitor for a multiplexed 8-digit 7-segment scan
// bus. It waits for each digit select to dwell with a stable segment pattern,
// then decodes the glyph back into a hex nibble, decimal point and status.

module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int NUM_DIGITS    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  an_in,
  input  logic [7:0]  seg_in,
  input  logic        clear,
  output logic [31:0] hex_out,
  output logic [7:0]  dp_out,
  output logic [7:0]  valid_out,
  output logic [7:0]  blank_out,
  output logic [7:0]  err_out,
  output logic        sel_err,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_SETTLE = 2'd1,
    S_HELD   = 2'd2
  } state_t;

  localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);

  state_t                  state;
  state_t                  state_nxt;
  logic [7:0]              cnt;
  logic [7:0]              cnt_nxt;
  logic [7:0]              cnt_inc;
  logic [7:0]              sel_q;
  logic [7:0]              seg_q;
  logic                    one_hot;
  logic                    multi_hot;
  logic                    same;
  logic                    capture;
  logic [2:0]              dig_idx;
  logic [3:0]              dec_nib;
  logic                    dec_valid;
  logic                    dec_blank;
  logic                    dec_err;
  logic [NUM_DIGITS-1:0]   mask;
  logic [NUM_DIGITS-1:0]   mask_set;

  assign one_hot   = $onehot(an_in);
  assign multi_hot = (an_in != 8'd0) && !one_hot;
  assign same      = (an_in == sel_q) && (seg_in == seg_q);
  assign cnt_inc   = cnt + 8'd1;

  // Previous-sample registers, dwell counter and FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_WAIT;
      cnt   <= 8'd0;
      sel_q <= 8'd0;
      seg_q <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sel_q <= an_in;
      seg_q <= seg_in;
    end
  end

  // Dwell tracking: count identical one-hot samples, capture once per dwell.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      S_WAIT: begin
        if (one_hot) begin
          state_nxt = S_SETTLE;
          cnt_nxt   = 8'd1;
        end else begin
          cnt_nxt = 8'd0;
        end
      end
      S_SETTLE: begin
        if (!one_hot) begin
          state_nxt = S_WAIT;
          cnt_nxt   = 8'd0;
        end else if (!same) begin
          cnt_nxt = 8'd1;
        end else if (cnt_inc == STABLE_LIM) begin
          capture   = 1'b1;
          state_nxt = S_HELD;
          cnt_nxt   = cnt_inc;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      S_HELD: begin
        if (!same) begin
          if (one_hot) begin
            state_nxt = S_SETTLE;
            cnt_nxt   = 8'd1;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = 8'd0;
          end
        end
      end
      default: begin
        state_nxt = S_WAIT;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Index of the selected digit; only meaningful when an_in is one-hot.
  always_comb begin
    dig_idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an_in[i]) dig_idx = 3'(i);
    end
  end

  // Glyph decode of segments a..g back into a hex nibble and status.
  always_comb begin
    dec_nib   = 4'h0;
    dec_valid = 1'b1;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    case (seg_in[7:1])
      7'h7E: dec_nib = 4'h0;
      7'h30: dec_nib = 4'h1;
      7'h6D: dec_nib = 4'h2;
      7'h79: dec_nib = 4'h3;
      7'h33: dec_nib = 4'h4;
      7'h5B: dec_nib = 4'h5;
      7'h5F: dec_nib = 4'h6;
      7'h70: dec_nib = 4'h7;
      7'h7F: dec_nib = 4'h8;
      7'h73: dec_nib = 4'h9;
      7'h77: dec_nib = 4'hA;
      7'h1F: dec_nib = 4'hB;
      7'h4E: dec_nib = 4'hC;
      7'h3D: dec_nib = 4'hD;
      7'h4F: dec_nib = 4'hE;
      7'h47: dec_nib = 4'hF;
      7'h00: begin
        dec_valid = 1'b0;
        dec_blank = 1'b1;
      end
      default: begin
        dec_valid = 1'b0;
        dec_err   = 1'b1;
      end
    endcase
  end

  // Frame mask with the newly captured digit included.
  always_comb begin
    mask_set          = mask;
    mask_set[dig_idx] = 1'b1;
  end

  // Captured digit data, sticky select error and frame completion; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_out    <= 32'd0;
      dp_out     <= 8'd0;
      valid_out  <= 8'd0;
      blank_out  <= 8'd0;
      err_out    <= 8'd0;
      sel_err    <= 1'b0;
      frame_done <= 1'b0;
      mask       <= '0;
    end else begin
      frame_done <= 1'b0;
      if (clear) begin
        hex_out   <= 32'd0;
        dp_out    <= 8'd0;
        valid_out <= 8'd0;
        blank_out <= 8'd0;
        err_out   <= 8'd0;
        sel_err   <= 1'b0;
        mask      <= '0;
      end else begin
        if (multi_hot) sel_err <= 1'b1;
        if (capture) begin
          hex_out[{dig_idx, 2'b00} +: 4] <= dec_nib;
          dp_out[dig_idx]                <= seg_in[0];
          valid_out[dig_idx]             <= dec_valid;
          blank_out[dig_idx]             <= dec_blank;
          err_out[dig_idx]               <= dec_err;
          if (&mask_set) begin
            mask       <= '0;
            frame_done <= 1'b1;
          end else begin
            mask <= mask_set;
          end
        end
      end
    end
  end

endmodule
